// File: rtl/gmii2fifo24.sv
// GMII receive parser: strips preamble/SFD and the Ethernet header, filters on EtherType,
// and unpacks the payload into 24-bit RGB pixel words for the downstream pixel FIFO.
module gmii2fifo24 #(
  parameter logic [15:0] ETHERTYPE    = 16'h88B5,
  parameter int unsigned MIN_PREAMBLE = 1
) (
  input  logic        clk125,
  input  logic        sys_rst,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  output logic [28:0] datain,
  output logic        recv_en,
  output logic        packet_en
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PREAMBLE = 3'd1;
  localparam logic [2:0] HEADER   = 3'd2;
  localparam logic [2:0] PAYHDR   = 3'd3;
  localparam logic [2:0] PIXEL    = 3'd4;
  localparam logic [2:0] DROP     = 3'd5;

  localparam logic [7:0] MIN_PRE = MIN_PREAMBLE[7:0];

  logic [2:0]  state;
  logic        armed;
  logic [7:0]  pre_cnt;
  logic [3:0]  byte_cnt;
  logic [7:0]  hi_byte;
  logic [3:0]  line_num;
  logic [15:0] remain;
  logic [1:0]  phase;
  logic [7:0]  r_byte;
  logic [7:0]  g_byte;
  logic        first_pix;

  always_ff @(posedge clk125) begin
    if (sys_rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      pre_cnt   <= '0;
      byte_cnt  <= '0;
      hi_byte   <= '0;
      line_num  <= '0;
      remain    <= '0;
      phase     <= '0;
      r_byte    <= '0;
      g_byte    <= '0;
      first_pix <= 1'b0;
      datain    <= '0;
      recv_en   <= 1'b0;
      packet_en <= 1'b0;
    end else begin
      recv_en <= 1'b0;
      if (!rx_dv) begin
        state     <= IDLE;
        packet_en <= 1'b0;
        armed     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            // after reset, a frame already in flight is never picked up mid-stream
            if (armed && rxd == 8'h55) begin
              state   <= PREAMBLE;
              pre_cnt <= 8'd1;
            end else begin
              state <= DROP;
            end
          end
          PREAMBLE: begin
            if (rxd == 8'h55) begin
              if (pre_cnt != 8'hFF) pre_cnt <= pre_cnt + 8'd1;
            end else if (rxd == 8'hD5 && pre_cnt >= MIN_PRE) begin
              state    <= HEADER;
              byte_cnt <= '0;
            end else begin
              state <= DROP;
            end
          end
          HEADER: begin
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd12) hi_byte <= rxd;
            if (byte_cnt == 4'd13) begin
              if ({hi_byte, rxd} == ETHERTYPE) begin
                state    <= PAYHDR;
                byte_cnt <= '0;
              end else begin
                state <= DROP;
              end
            end
          end
          PAYHDR: begin
            byte_cnt <= byte_cnt + 4'd1;
            case (byte_cnt[1:0])
              2'd0: hi_byte <= rxd;
              2'd1: line_num <= rxd[3:0];
              2'd2: hi_byte <= rxd;
              default: begin
                if ({hi_byte, rxd} == 16'h0000) begin
                  state <= DROP;
                end else begin
                  state     <= PIXEL;
                  remain    <= {hi_byte, rxd};
                  packet_en <= 1'b1;
                  first_pix <= 1'b1;
                  phase     <= '0;
                end
              end
            endcase
          end
          PIXEL: begin
            case (phase)
              2'd0: begin
                r_byte <= rxd;
                phase  <= 2'd1;
              end
              2'd1: begin
                g_byte <= rxd;
                phase  <= 2'd2;
              end
              default: begin
                datain    <= {first_pix, line_num, r_byte, g_byte, rxd};
                recv_en   <= 1'b1;
                first_pix <= 1'b0;
                remain    <= remain - 16'd1;
                phase     <= 2'd0;
                // packet_en stays up through the last strobe and drops from DROP
                if (remain == 16'd1) state <= DROP;
              end
            endcase
          end
          DROP: packet_en <= 1'b0;
          default: state <= DROP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gmii2fifo24.sv
// Randomized scoreboard bench for gmii2fifo24: a frame-level model predicts strobe
// slots, pixel words and the packet_en window; a monitor compares every cycle.
module tb_gmii2fifo24;

  localparam int MAXS = 16384;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          slot;
    logic [28:0] data;
  } exp_t;

  logic        clk125 = 1'b0;
  logic        sys_rst = 1'b1;
  logic [7:0]  rxd = 8'h00;
  logic        rx_dv = 1'b0;
  logic [28:0] datain;
  logic        recv_en;
  logic        packet_en;

  int   slot = 0;
  int   checks = 0;
  int   failures = 0;
  bit   running = 1'b1;
  exp_t q[$];
  bit   exp_pkt[MAXS];
  bit   exp_zero[MAXS];
  logic [28:0] hold = '0;

  gmii2fifo24 #(.ETHERTYPE(16'h88B5), .MIN_PREAMBLE(1)) dut (
    .clk125(clk125), .sys_rst(sys_rst), .rxd(rxd), .rx_dv(rx_dv),
    .datain(datain), .recv_en(recv_en), .packet_en(packet_en)
  );

  always #4 clk125 = ~clk125;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s slot=%0d got=%h want=%h", nm, slot, act, want);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic dv, input logic rst);
    @(posedge clk125);
    #1;
    rxd = d;
    rx_dv = dv;
    sys_rst = rst;
    slot++;
  endtask

  function automatic bq_t rnd_bytes(input int cnt);
    bq_t b;
    for (int i = 0; i < cnt; i++) b.push_back(8'($urandom));
    return b;
  endfunction

  function automatic bq_t mk(input int pre, input logic [15:0] eth, input logic [15:0] line,
                             input logic [15:0] n, input bq_t pix, input int tail);
    bq_t b;
    for (int i = 0; i < pre; i++) b.push_back(8'h55);
    b.push_back(8'hD5);
    for (int i = 0; i < 12; i++) b.push_back(8'($urandom));
    b.push_back(eth[15:8]);  b.push_back(eth[7:0]);
    b.push_back(line[15:8]); b.push_back(line[7:0]);
    b.push_back(n[15:8]);    b.push_back(n[7:0]);
    foreach (pix[i]) b.push_back(pix[i]);
    for (int i = 0; i < tail; i++) b.push_back(8'($urandom));
    return b;
  endfunction

  // Frame-level prediction: byte i of the frame sits on the bus in slot start+i and
  // any registered response to it is visible one slot later.
  task automatic model(input bq_t b, input int start);
    int n, p, ph, pix, avail, k, last;
    logic [15:0] line, npx;
    exp_t e;
    n = b.size();
    p = 0;
    while (p < n && b[p] == 8'h55) p++;
    if (p < 1 || p >= n || b[p] != 8'hD5) return;
    ph = p + 15;
    if (n < ph) return;
    if ({b[ph-2], b[ph-1]} != 16'h88B5) return;
    if (n < ph + 4) return;
    line = {b[ph], b[ph+1]};
    npx  = {b[ph+2], b[ph+3]};
    if (npx == 16'd0) return;
    pix   = ph + 4;
    avail = (n - pix) / 3;
    k     = (avail < int'(npx)) ? avail : int'(npx);
    for (int i = 0; i < k; i++) begin
      e.slot = start + pix + 3 * i + 3;
      e.data = {(i == 0), line[3:0], b[pix+3*i], b[pix+3*i+1], b[pix+3*i+2]};
      q.push_back(e);
    end
    last = (k == int'(npx)) ? start + pix + 3 * int'(npx) : start + n;
    for (int s = start + ph + 4; s <= last; s++) exp_pkt[s] = 1'b1;
  endtask

  task automatic send_frame(input bq_t b, input int gap, input int rst_at);
    int start;
    start = slot + 1;
    if (rst_at < 0) model(b, start);
    else exp_zero[start + rst_at + 1] = 1'b1;
    foreach (b[i]) drive(b[i], 1'b1, (i == rst_at));
    for (int i = 0; i < gap; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk125);
      if (running && slot < MAXS) begin
        if (exp_zero[slot]) begin
          hold = '0;
          chk("reset_recv_en", {31'd0, recv_en}, 32'd0);
        end
        if (recv_en === 1'b1) begin
          if (q.size() == 0) begin
            chk("unexpected_strobe", {3'd0, datain}, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("strobe_slot", e.slot, slot);
            chk("pixel_word", {3'd0, datain}, {3'd0, e.data});
            hold = e.data;
          end
        end else begin
          if (q.size() > 0 && q[0].slot <= slot) begin
            e = q.pop_front();
            chk("missing_strobe", {31'd0, recv_en}, 32'd1);
            hold = e.data;
          end
          chk("datain_hold", {3'd0, datain}, {3'd0, hold});
        end
        chk("packet_en", {31'd0, packet_en}, {31'd0, exp_pkt[slot]});
      end
    end
  end

  initial begin
    bq_t b, px;
    int npx, nb, tail;
    logic [15:0] eth;
    // reset held while rx_dv toggles
    exp_zero[1] = 1'b1; exp_zero[2] = 1'b1; exp_zero[3] = 1'b1;
    drive(8'h55, 1'b1, 1'b1);
    drive(8'hD5, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0);

    px = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_frame(mk(7, 16'h88B5, 16'h0012, 16'd2, px, 4), 1, -1);
    send_frame(mk(7, 16'h0800, 16'h0012, 16'd2, px, 4), 1, -1);
    send_frame(mk(7, 16'h88B5, 16'h0005, 16'd3, rnd_bytes(7), 0), 1, -1);

    b = mk(7, 16'h88B5, 16'h0001, 16'd2, rnd_bytes(6), 2);
    b[1] = 8'h54;
    send_frame(b, 1, -1);
    send_frame(mk(2, 16'h88B5, 16'h0007, 16'd1, rnd_bytes(3), 0), 1, -1);
    send_frame(mk(7, 16'h88B5, 16'h0009, 16'd0, rnd_bytes(6), 3), 1, -1);
    send_frame(mk(1, 16'h88B5, 16'h000A, 16'd2, rnd_bytes(6), 4), 1, -1);

    send_frame(mk(7, 16'h88B5, 16'h0003, 16'd2, rnd_bytes(6), 0), 1, -1);
    send_frame(mk(7, 16'h88B5, 16'h0004, 16'd2, rnd_bytes(6), 0), 1, -1);

    send_frame(mk(7, 16'h88B5, 16'h0006, 16'd2, rnd_bytes(6), 0), 2, 12);
    send_frame(mk(3, 16'h88B5, 16'h000B, 16'd2, rnd_bytes(6), 1), 1, -1);

    for (int f = 0; f < 40; f++) begin
      npx  = $urandom_range(0, 6);
      eth  = ($urandom_range(0, 3) == 0) ? 16'h0800 : 16'h88B5;
      nb   = 3 * npx;
      tail = $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) begin
        nb   = $urandom_range(0, 3 * npx);
        tail = 0;
      end
      send_frame(mk($urandom_range(1, 8), eth, 16'($urandom), 16'(npx), rnd_bytes(nb), tail),
                 $urandom_range(1, 3), -1);
    end

    for (int i = 0; i < 10; i++) drive(8'h00, 1'b0, 1'b0);
    running = 1'b0;
    chk("leftover_expected", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
